// File: rtl/half_array_collector_if.sv
// Filter-output-to-collector link: vector stream in, three half-pel planes plus
// frame handshake and status out.
interface half_array_collector_if #(
  parameter int NUM_PIXEL = 8,
  parameter int ROW_W     = (NUM_PIXEL + 7) * 8
);
  localparam int CNT_W = $clog2(3 * NUM_PIXEL + 1);

  logic                       in_valid;
  logic                       in_ready;
  logic [7:0]                 in_sel;
  logic [ROW_W-1:0]           in_data;
  logic [NUM_PIXEL*ROW_W-1:0] a_half_array;
  logic [NUM_PIXEL*ROW_W-1:0] b_half_array;
  logic [NUM_PIXEL*ROW_W-1:0] c_half_array;
  logic                       frame_valid;
  logic                       frame_ack;
  logic [CNT_W-1:0]           rows_done;
  logic                       sel_err;
  logic                       dup_err;

  modport master (
    output in_valid, in_sel, in_data, frame_ack,
    input  in_ready, a_half_array, b_half_array, c_half_array,
    input  frame_valid, rows_done, sel_err, dup_err
  );

  modport slave (
    input  in_valid, in_sel, in_data, frame_ack,
    output in_ready, a_half_array, b_half_array, c_half_array,
    output frame_valid, rows_done, sel_err, dup_err
  );
endinterface

// File: rtl/half_array_collector.sv
// Files each filtered row into half-pel plane A/B/C by its select code and
// presents all three planes once every row of the frame has arrived.
module half_array_collector #(
  parameter int NUM_PIXEL = 8,
  parameter int ROW_W     = (NUM_PIXEL + 7) * 8,
  parameter int BASE_SEL  = 2 * NUM_PIXEL + 7
) (
  input  logic                    clock,
  input  logic                    reset,
  half_array_collector_if.slave   bus
);
  localparam int NUM_ROWS = 3 * NUM_PIXEL;
  localparam int IDX_W    = $clog2(NUM_ROWS);
  localparam int CNT_W    = $clog2(NUM_ROWS + 1);

  typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [NUM_ROWS-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]    rows_done_q, rows_done_d;
  logic                sel_err_q, sel_err_d;
  logic                dup_err_q, dup_err_d;
  logic [ROW_W-1:0]    plane_q [NUM_ROWS];

  logic             accept, in_range, wr_row, new_row, last_row;
  logic [7:0]       sel_off;
  logic [IDX_W-1:0] row_idx;

  // Plane A, B, C rows are stored back to back, so the select offset is the
  // storage index directly (plane*NUM_PIXEL + row).
  assign accept   = bus.in_valid && (state_q == COLLECT);
  assign sel_off  = bus.in_sel - 8'(BASE_SEL);
  assign in_range = (bus.in_sel >= 8'(BASE_SEL)) && (sel_off < 8'(NUM_ROWS));
  assign row_idx  = sel_off[IDX_W-1:0];
  assign wr_row   = accept && in_range;
  assign new_row  = wr_row && !mask_q[row_idx];
  assign last_row = new_row && (rows_done_q == CNT_W'(NUM_ROWS - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= COLLECT;
      mask_q      <= '0;
      rows_done_q <= '0;
      sel_err_q   <= 1'b0;
      dup_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      rows_done_q <= rows_done_d;
      sel_err_q   <= sel_err_d;
      dup_err_q   <= dup_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: if (last_row)      state_d = FULL;
      FULL:    if (bus.frame_ack) state_d = COLLECT;
    endcase
  end

  always_comb begin
    mask_d      = mask_q;
    rows_done_d = rows_done_q;
    sel_err_d   = sel_err_q;
    dup_err_d   = dup_err_q;
    if ((state_q == FULL) && bus.frame_ack) begin
      mask_d      = '0;
      rows_done_d = '0;
    end
    if (new_row) begin
      mask_d[row_idx] = 1'b1;
      rows_done_d     = rows_done_q + CNT_W'(1);
    end
    if (wr_row && mask_q[row_idx]) dup_err_d = 1'b1;
    if (accept && !in_range)       sel_err_d = 1'b1;
  end

  always_comb begin
    bus.in_ready    = (state_q == COLLECT);
    bus.frame_valid = (state_q == FULL);
    bus.rows_done   = rows_done_q;
    bus.sel_err     = sel_err_q;
    bus.dup_err     = dup_err_q;
  end

  // Plane storage: rewrites on duplicates too; held across frame_ack.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ROWS; i++) plane_q[i] <= '0;
    end else if (wr_row) begin
      plane_q[row_idx] <= bus.in_data;
    end
  end

  for (genvar r = 0; r < NUM_PIXEL; r++) begin : g_rows
    assign bus.a_half_array[r*ROW_W +: ROW_W] = plane_q[r];
    assign bus.b_half_array[r*ROW_W +: ROW_W] = plane_q[NUM_PIXEL + r];
    assign bus.c_half_array[r*ROW_W +: ROW_W] = plane_q[2*NUM_PIXEL + r];
  end
endmodule

// File: tb/tb_half_array_collector.sv
// Directed-vector bench for half_array_collector: frame fill in both orders,
// ack/hold handshake, select and duplicate errors, asynchronous mid-frame reset.
module tb_half_array_collector;
  localparam int NP = 8;
  localparam int RW = 120;
  localparam int NR = 24;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] exp_row [NR];

  half_array_collector_if #(.NUM_PIXEL(NP), .ROW_W(RW)) bus ();

  half_array_collector #(.NUM_PIXEL(NP), .ROW_W(RW), .BASE_SEL(23)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [RW-1:0] pat(input logic [7:0] b);
    return {15{b}};
  endfunction

  function automatic logic [RW-1:0] dut_row(input int idx);
    if (idx < NP)         return bus.a_half_array[idx*RW +: RW];
    else if (idx < 2*NP)  return bus.b_half_array[(idx-NP)*RW +: RW];
    else                  return bus.c_half_array[(idx-2*NP)*RW +: RW];
  endfunction

  function automatic int plane_diffs();
    int n = 0;
    for (int r = 0; r < NR; r++) if (dut_row(r) !== pat(exp_row[r])) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] s, input logic [7:0] b, input logic ack);
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.in_data   = pat(b);
    bus.frame_ack = ack;
  endtask

  task automatic do_reset();
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    reset = 1'b0;
    for (int r = 0; r < NR; r++) exp_row[r] = 8'h00;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    for (int r = 0; r < NR; r++) exp_row[r] = 8'h00;
    reset = 1'b0;
    #2;
    checks++; if (bus.frame_valid !== 1'b0) begin failures++; $display("FAIL reset_frame_valid got=%b want=0", bus.frame_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    checks++; if (bus.rows_done !== 5'd0) begin failures++; $display("FAIL reset_rows_done got=%0d want=0", bus.rows_done); end
    checks++; if ({bus.sel_err, bus.dup_err} !== 2'b00) begin failures++; $display("FAIL reset_errs got=%b want=00", {bus.sel_err, bus.dup_err}); end
    checks++; if (plane_diffs() !== 0) begin failures++; $display("FAIL reset_planes got=%0d bad rows want=0", plane_diffs()); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_inorder();
    for (int s = 23; s <= 46; s++) begin
      drive(1'b1, 8'(s), 8'(s), 1'b0);
      exp_row[s-23] = 8'(s);
      tick();
      if (s == 45) begin
        checks++; if (bus.frame_valid !== 1'b0) begin failures++; $display("FAIL inorder_early_fv got=%b want=0", bus.frame_valid); end
        checks++; if (bus.rows_done !== 5'd23) begin failures++; $display("FAIL inorder_rows23 got=%0d want=23", bus.rows_done); end
      end
    end
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    checks++; if (bus.frame_valid !== 1'b1) begin failures++; $display("FAIL inorder_fv got=%b want=1", bus.frame_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL inorder_ready got=%b want=0", bus.in_ready); end
    checks++; if (bus.rows_done !== 5'd24) begin failures++; $display("FAIL inorder_rows got=%0d want=24", bus.rows_done); end
    checks++; if (bus.a_half_array[0 +: RW] !== pat(8'h17)) begin failures++; $display("FAIL inorder_a_row0 got=%h want=%h", bus.a_half_array[0 +: RW], pat(8'h17)); end
    checks++; if (bus.c_half_array[7*RW +: RW] !== pat(8'h2E)) begin failures++; $display("FAIL inorder_c_row7 got=%h want=%h", bus.c_half_array[7*RW +: RW], pat(8'h2E)); end
    checks++; if (plane_diffs() !== 0) begin failures++; $display("FAIL inorder_planes got=%0d bad rows want=0", plane_diffs()); end
  endtask

  task automatic test_reverse_toggle();
    do_reset();
    for (int s = 46; s >= 23; s--) begin
      drive(1'b1, 8'(s), 8'(s), 1'b0);
      exp_row[s-23] = 8'(s);
      tick();
      if (s == 24) begin
        checks++; if (bus.frame_valid !== 1'b0) begin failures++; $display("FAIL reverse_early_fv got=%b want=0", bus.frame_valid); end
      end
      if (s == 23) begin
        checks++; if (bus.frame_valid !== 1'b1) begin failures++; $display("FAIL reverse_fv got=%b want=1", bus.frame_valid); end
      end
      drive(1'b0, 8'd0, 8'd0, 1'b0);
      tick();
    end
    checks++; if (bus.rows_done !== 5'd24) begin failures++; $display("FAIL reverse_rows got=%0d want=24", bus.rows_done); end
    checks++; if (plane_diffs() !== 0) begin failures++; $display("FAIL reverse_planes got=%0d bad rows want=0", plane_diffs()); end
  endtask

  task automatic test_ack_hold();
    drive(1'b1, 8'd23, 8'h55, 1'b0);
    repeat (3) tick();
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL hold_ready got=%b want=0", bus.in_ready); end
    checks++; if (bus.rows_done !== 5'd24) begin failures++; $display("FAIL hold_rows got=%0d want=24", bus.rows_done); end
    checks++; if (bus.a_half_array[0 +: RW] !== pat(8'h17)) begin failures++; $display("FAIL hold_a_row0 got=%h want=%h", bus.a_half_array[0 +: RW], pat(8'h17)); end
    drive(1'b1, 8'd23, 8'h55, 1'b1);
    tick();
    checks++; if (bus.frame_valid !== 1'b0) begin failures++; $display("FAIL ack_fv got=%b want=0", bus.frame_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL ack_ready got=%b want=1", bus.in_ready); end
    checks++; if (bus.rows_done !== 5'd0) begin failures++; $display("FAIL ack_rows got=%0d want=0", bus.rows_done); end
    checks++; if (plane_diffs() !== 0) begin failures++; $display("FAIL ack_planes got=%0d bad rows want=0", plane_diffs()); end
    drive(1'b1, 8'd23, 8'h55, 1'b0);
    exp_row[0] = 8'h55;
    tick();
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    checks++; if (bus.rows_done !== 5'd1) begin failures++; $display("FAIL after_ack_rows got=%0d want=1", bus.rows_done); end
    checks++; if (bus.a_half_array[0 +: RW] !== pat(8'h55)) begin failures++; $display("FAIL after_ack_a_row0 got=%h want=%h", bus.a_half_array[0 +: RW], pat(8'h55)); end
    checks++; if (plane_diffs() !== 0) begin failures++; $display("FAIL after_ack_planes got=%0d bad rows want=0", plane_diffs()); end
  endtask

  task automatic test_sel_err();
    logic [7:0] bad_sel [2];
    bad_sel[0] = 8'd5;
    bad_sel[1] = 8'd47;
    checks++; if (bus.sel_err !== 1'b0) begin failures++; $display("FAIL sel_err_pre got=%b want=0", bus.sel_err); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, bad_sel[i], 8'h99, 1'b0);
      tick();
      checks++; if (bus.sel_err !== 1'b1) begin failures++; $display("FAIL sel_err_%0d got=%b want=1", bad_sel[i], bus.sel_err); end
      checks++; if (bus.rows_done !== 5'd1) begin failures++; $display("FAIL sel_rows_%0d got=%0d want=1", bad_sel[i], bus.rows_done); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL sel_ready_%0d got=%b want=1", bad_sel[i], bus.in_ready); end
      checks++; if (plane_diffs() !== 0) begin failures++; $display("FAIL sel_planes_%0d got=%0d bad rows want=0", bad_sel[i], plane_diffs()); end
    end
    drive(1'b0, 8'd0, 8'd0, 1'b0);
  endtask

  task automatic test_dup();
    checks++; if (bus.dup_err !== 1'b0) begin failures++; $display("FAIL dup_pre got=%b want=0", bus.dup_err); end
    drive(1'b1, 8'd30, 8'h11, 1'b0);
    exp_row[7] = 8'h11;
    tick();
    checks++; if (bus.rows_done !== 5'd2) begin failures++; $display("FAIL dup_first_rows got=%0d want=2", bus.rows_done); end
    checks++; if (bus.dup_err !== 1'b0) begin failures++; $display("FAIL dup_first_err got=%b want=0", bus.dup_err); end
    drive(1'b1, 8'd30, 8'h22, 1'b0);
    exp_row[7] = 8'h22;
    tick();
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    checks++; if (bus.dup_err !== 1'b1) begin failures++; $display("FAIL dup_err got=%b want=1", bus.dup_err); end
    checks++; if (bus.rows_done !== 5'd2) begin failures++; $display("FAIL dup_rows got=%0d want=2", bus.rows_done); end
    checks++; if (bus.a_half_array[7*RW +: RW] !== pat(8'h22)) begin failures++; $display("FAIL dup_a_row7 got=%h want=%h", bus.a_half_array[7*RW +: RW], pat(8'h22)); end
    checks++; if (plane_diffs() !== 0) begin failures++; $display("FAIL dup_planes got=%0d bad rows want=0", plane_diffs()); end
  endtask

  task automatic test_reset_mid();
    for (int s = 23; s <= 32; s++) begin
      drive(1'b1, 8'(s), 8'(s) ^ 8'h3C, 1'b0);
      exp_row[s-23] = 8'(s) ^ 8'h3C;
      tick();
    end
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    checks++; if (bus.rows_done !== 5'd10) begin failures++; $display("FAIL mid_rows_pre got=%0d want=10", bus.rows_done); end
    #2;
    reset = 1'b0;
    for (int r = 0; r < NR; r++) exp_row[r] = 8'h00;
    #1;
    checks++; if (bus.rows_done !== 5'd0) begin failures++; $display("FAIL mid_rst_rows got=%0d want=0", bus.rows_done); end
    checks++; if ({bus.frame_valid, bus.in_ready} !== 2'b01) begin failures++; $display("FAIL mid_rst_fv_rdy got=%b want=01", {bus.frame_valid, bus.in_ready}); end
    checks++; if ({bus.sel_err, bus.dup_err} !== 2'b00) begin failures++; $display("FAIL mid_rst_errs got=%b want=00", {bus.sel_err, bus.dup_err}); end
    checks++; if (plane_diffs() !== 0) begin failures++; $display("FAIL mid_rst_planes got=%0d bad rows want=0", plane_diffs()); end
    tick();
    reset = 1'b1;
    tick();
    for (int s = 23; s <= 46; s++) begin
      drive(1'b1, 8'(s), 8'(s) + 8'h40, 1'b0);
      exp_row[s-23] = 8'(s) + 8'h40;
      tick();
    end
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    checks++; if (bus.frame_valid !== 1'b1) begin failures++; $display("FAIL post_rst_fv got=%b want=1", bus.frame_valid); end
    checks++; if (bus.rows_done !== 5'd24) begin failures++; $display("FAIL post_rst_rows got=%0d want=24", bus.rows_done); end
    checks++; if (plane_diffs() !== 0) begin failures++; $display("FAIL post_rst_planes got=%0d bad rows want=0", plane_diffs()); end
  endtask

  initial begin
    test_reset();
    test_inorder();
    test_reverse_toggle();
    test_ack_hold();
    test_sel_err();
    test_dup();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
